// File: rtl/dm_mm2s_responder.sv
// dm_mm2s_responder
// Memory-side responder for the 72-bit DataMover MM2S command stream.
// Accepts one read command at a time, fetches 256-bit words from a memory
// with fixed 1-cycle read latency and streams them out with byte-accurate
// tkeep/tlast.
// Optional feature: define DM_RESP_STS_EN to add the 8-bit status channel
// and the STS state. Without it, errored commands are silently consumed.
module dm_mm2s_responder #(
  parameter int MEM_AW    = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [71:0]       s_axis_cmd_tdata,
  input  logic              s_axis_cmd_tvalid,
  output logic              s_axis_cmd_tready,
  output logic [255:0]      m_axis_tdata,
  output logic [31:0]       m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [255:0]      mem_rdata
`ifdef DM_RESP_STS_EN
  ,
  output logic [7:0]        m_axis_sts_tdata,
  output logic              m_axis_sts_tvalid,
  input  logic              m_axis_sts_tready
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [27:0] MEM_WORDS = 28'(1) << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
`ifdef DM_RESP_STS_EN
    ,
    S_STS
`endif
  } state_t;

  state_t            state;
  logic              cmd_rdy;
  logic [MEM_AW-1:0] rd_addr;
  logic [18:0]       beats_r;
  logic [18:0]       issued;
  logic [4:0]        rem_r;
  logic              eof_r;
`ifdef DM_RESP_STS_EN
  logic [3:0]        tag_r;
`endif

  // Command decode
  logic [22:0] cmd_btt;
  logic [26:0] cmd_waddr;
  logic [18:0] cmd_beats;
  logic [27:0] cmd_end;
  logic        cmd_slverr;
  logic        cmd_decerr;
  logic        cmd_fire;
  logic        unused_cmd;

  // Output buffer and read credit
  logic [255:0]       buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_final;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      occ;
  logic               pend;
  logic               pend_final;
  logic               issue;
  logic               last_issue;
  logic               pop;
  logic               head_final;
  logic [31:0]        keep_tail;

  assign unused_cmd = ^{s_axis_cmd_tdata[71:64], s_axis_cmd_tdata[36:24]};

  // Decode the command word and evaluate the acceptance-time error checks
  always_comb begin
    cmd_btt    = s_axis_cmd_tdata[22:0];
    cmd_waddr  = s_axis_cmd_tdata[63:37];
    cmd_beats  = {1'b0, cmd_btt[22:5]} + 19'(|cmd_btt[4:0]);
    cmd_end    = {1'b0, cmd_waddr} + 28'(cmd_beats);
    cmd_slverr = (cmd_btt == '0);
    cmd_decerr = (cmd_end > MEM_WORDS);
    cmd_fire   = cmd_rdy && s_axis_cmd_tvalid;
  end

  // Read issue gated by credit: buffered beats plus the read in flight
  always_comb begin
    issue      = (state == S_READ) && ((occ + CW'(pend)) < CW'(BUF_DEPTH));
    last_issue = issue && (issued == beats_r - 19'd1);
    mem_en     = issue;
    mem_addr   = rd_addr;
  end

  // Buffer head drives the output stream; tail keep mask from rem
  always_comb begin
    m_axis_tvalid = (occ != '0);
    head_final    = buf_final[rd_ptr];
    pop           = m_axis_tvalid && m_axis_tready;
    for (int unsigned i = 0; i < 32; i++) begin
      keep_tail[i] = (i < 32'(rem_r));
    end
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tdata = buf_data[rd_ptr];
      m_axis_tkeep = (head_final && (rem_r != '0)) ? keep_tail : '1;
      m_axis_tlast = head_final && eof_r;
    end
  end

  assign s_axis_cmd_tready = cmd_rdy;

  // Command FSM: accept, issue reads, drain, optionally report status
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_rdy <= 1'b0;
      rd_addr <= '0;
      beats_r <= '0;
      issued  <= '0;
      rem_r   <= '0;
      eof_r   <= 1'b0;
`ifdef DM_RESP_STS_EN
      tag_r             <= '0;
      m_axis_sts_tvalid <= 1'b0;
      m_axis_sts_tdata  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_fire) begin
            beats_r <= cmd_beats;
            rem_r   <= cmd_btt[4:0];
            eof_r   <= s_axis_cmd_tdata[23];
            rd_addr <= cmd_waddr[MEM_AW-1:0];
            issued  <= '0;
`ifdef DM_RESP_STS_EN
            tag_r   <= s_axis_cmd_tdata[27:24];
            cmd_rdy <= 1'b0;
            if (cmd_slverr || cmd_decerr) begin
              state             <= S_STS;
              m_axis_sts_tvalid <= 1'b1;
              m_axis_sts_tdata  <= {1'b0, cmd_slverr, cmd_decerr, 1'b0,
                                    s_axis_cmd_tdata[27:24]};
            end else begin
              state <= S_READ;
            end
`else
            if (!(cmd_slverr || cmd_decerr)) begin
              state   <= S_READ;
              cmd_rdy <= 1'b0;
            end
`endif
          end
        end
        S_READ: begin
          if (issue) begin
            rd_addr <= rd_addr + MEM_AW'(1);
            issued  <= issued + 19'd1;
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && head_final) begin
`ifdef DM_RESP_STS_EN
            state             <= S_STS;
            m_axis_sts_tvalid <= 1'b1;
            m_axis_sts_tdata  <= {4'b1000, tag_r};
`else
            state   <= S_IDLE;
            cmd_rdy <= 1'b1;
`endif
          end
        end
`ifdef DM_RESP_STS_EN
        S_STS: begin
          if (m_axis_sts_tready) begin
            m_axis_sts_tvalid <= 1'b0;
            state             <= S_IDLE;
            cmd_rdy           <= 1'b1;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          cmd_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Buffer pointers, occupancy and the single in-flight read marker
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      pend       <= 1'b0;
      pend_final <= 1'b0;
    end else begin
      pend       <= issue;
      pend_final <= last_issue;
      if (pend) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({pend, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage: memory data lands one cycle after its read was issued
  always_ff @(posedge clk) begin
    if (pend) begin
      buf_data[wr_ptr]  <= mem_rdata;
      buf_final[wr_ptr] <= pend_final;
    end
  end

endmodule

// File: tb/tb_dm_mm2s_responder.sv
// Self-checking bench for dm_mm2s_responder (MEM_AW=16, BUF_DEPTH=4).
module tb_dm_mm2s_responder;
  localparam int MEM_AW    = 16;
  localparam int BUF_DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [71:0]  cmd_tdata;
  logic         cmd_tvalid;
  logic         cmd_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic         mem_en;
  logic [15:0]  mem_addr;
  logic [255:0] mem_rdata;
`ifdef DM_RESP_STS_EN
  logic [7:0]   sts_tdata;
  logic         sts_tvalid;
  logic         sts_tready;
`endif

  always #5 clk = ~clk;

  dm_mm2s_responder #(.MEM_AW(MEM_AW), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_cmd_tdata(cmd_tdata), .s_axis_cmd_tvalid(cmd_tvalid),
    .s_axis_cmd_tready(cmd_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef DM_RESP_STS_EN
    , .m_axis_sts_tdata(sts_tdata), .m_axis_sts_tvalid(sts_tvalid),
    .m_axis_sts_tready(sts_tready)
`endif
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         fin;
  } beat_t;

  typedef struct {
    logic [22:0] btt;
    logic [31:0] addr;
    logic        eof;
    logic [3:0]  tag;
    int          rmode;
    int          exp_beats;
    logic [31:0] exp_keep;
    logic [7:0]  exp_sts;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int smode = 0;

  beat_t       exp_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  sts_q[$];

  int hs_cyc = 0, first_en = -1, first_v = -1, beat_done_cyc = -1, sts_cyc = -1;
  int beat_cnt = 0, n_iss = 0, n_acc = 0;
  logic [31:0]  last_keep;
  logic [7:0]   last_sts = '0;
  logic         prev_stall = 1'b0;
  logic [255:0] pd;
  logic [31:0]  pk;
  logic         pl;
  beat_t        mon_e;

  function automatic logic [255:0] word_of(input logic [15:0] a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = {a, a ^ 16'(j * 16'h1111)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: 1-cycle read latency, garbage when not enabled
  initial begin : mem_model
    logic        en_s;
    logic [15:0] a_s;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      en_s = mem_en;
      a_s  = mem_addr;
      @(posedge clk);
      #1;
      if (en_s) mem_rdata = word_of(a_s);
      else for (int j = 0; j < 8; j++) mem_rdata[j*32 +: 32] = $urandom;
    end
  end

  // Sink ready patterns: 0 always, 1 toggle, 2 random
  initial begin : ready_drv
    m_tready = 1'b1;
`ifdef DM_RESP_STS_EN
    sts_tready = 1'b1;
`endif
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
`ifdef DM_RESP_STS_EN
      sts_tready = (smode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`endif
    end
  end

  // Monitor: scoreboard for reads, beats and status; stall stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      n_iss = 0;
      n_acc = 0;
    end else begin
      if (cmd_tvalid && cmd_tready) begin
        hs_cyc = cyc; first_en = -1; first_v = -1;
      end
      if (mem_en) begin
        if (first_en < 0) first_en = cyc;
        chk("mem_en_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("mem_addr", mem_addr, addr_q.pop_front());
        n_iss++;
        chk("occupancy_le_depth", (n_iss - n_acc) <= BUF_DEPTH, 1);
      end
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, pd);
        chk("stall_tkeep", m_tkeep, pk);
        chk("stall_tlast", m_tlast, pl);
      end
      if (m_tvalid && m_tready) begin
        n_acc++;
        beat_cnt++;
        last_keep = m_tkeep;
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_data", m_tdata, mon_e.data);
          chk("beat_keep", m_tkeep, mon_e.keep);
          chk("beat_last", m_tlast, mon_e.last);
          if (mon_e.fin) beat_done_cyc = cyc;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast;
`ifdef DM_RESP_STS_EN
      if (sts_tvalid && sts_tready) begin
        sts_cyc = cyc;
        last_sts = sts_tdata;
        chk("sts_expected", sts_q.size() != 0, 1);
        if (sts_q.size() != 0) chk("sts_tdata", sts_tdata, sts_q.pop_front());
      end
`endif
    end
  end

  // Reference model: expected reads, beats and status straight from the rules
  task automatic model_push(input logic [22:0] btt, input logic [31:0] addr,
                            input logic eof, input logic [3:0] tag, output int mb);
    longint wa, nb;
    int     r;
    logic   slv, dec;
    beat_t  b;
    wa  = longint'(addr >> 5);
    nb  = (longint'(btt) + 31) / 32;
    r   = int'(btt % 32);
    slv = (btt == 0);
    dec = (wa + nb) > (longint'(1) << MEM_AW);
    mb  = 0;
    if (!slv && !dec) begin
      mb = int'(nb);
      for (int i = 0; i < mb; i++) begin
        addr_q.push_back(16'(wa + i));
        b.data = word_of(16'(wa + i));
        b.fin  = (i == mb - 1);
        b.keep = (b.fin && r != 0) ? 32'((longint'(1) << r) - 1) : 32'hFFFF_FFFF;
        b.last = b.fin && eof;
        exp_q.push_back(b);
      end
    end
`ifdef DM_RESP_STS_EN
    sts_q.push_back({~(slv | dec), slv, dec, 1'b0, tag});
`endif
  endtask

  task automatic wait_hs(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (cmd_tready) break;
      @(posedge clk);
      #1;
    end
    if (k == 300) begin
      errors++;
      $display("FAIL %s: cmd_tready timeout, got 0 expected 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && addr_q.size() == 0 && sts_q.size() == 0 && cmd_tready) break;
    end
    if (k == 3000) begin
      errors++;
      $display("FAIL %s: completion timeout, pending beats %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic run_cmd(input logic [22:0] btt, input logic [31:0] addr, input logic eof,
                         input logic [3:0] tag, output int nb, output logic [31:0] lk,
                         output int mb);
    model_push(btt, addr, eof, tag, mb);
    beat_cnt = 0;
    cmd_tdata = {8'($urandom), addr, 4'($urandom), tag, eof, btt};
    cmd_tvalid = 1'b1;
    wait_hs("cmd_hs");
    cmd_tvalid = 1'b0;
    wait_idle("cmd_done");
    nb = beat_cnt;
    lk = last_keep;
    if (rmode == 0 && mb > 0) begin
      chk("t_first_mem_en", first_en, hs_cyc + 1);
      chk("t_first_tvalid", first_v, hs_cyc + 3);
      chk("t_complete", beat_done_cyc, hs_cyc + 2 + mb);
    end
  endtask

  vec_t        vecs[8];
  int          nb, mb, base;
  logic [31:0] lk;
  logic [31:0] wa;
  logic [22:0] rbtt;

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{23'd96,  32'h0000_0040, 1'b1, 4'h3, 0, 3,  32'hFFFF_FFFF, 8'h83};
    vecs[1] = '{23'd40,  32'h0000_0100, 1'b0, 4'h5, 0, 2,  32'h0000_00FF, 8'h85};
    vecs[2] = '{23'd320, 32'h0000_2000, 1'b1, 4'h7, 1, 10, 32'hFFFF_FFFF, 8'h87};
    vecs[3] = '{23'd0,   32'h0000_0000, 1'b1, 4'h1, 0, 0,  32'h0,         8'h41};
    vecs[4] = '{23'd64,  32'h001F_FFE0, 1'b1, 4'h2, 0, 0,  32'h0,         8'h22};
    vecs[5] = '{23'd32,  32'h001F_FFE0, 1'b1, 4'h9, 0, 1,  32'hFFFF_FFFF, 8'h89};
    vecs[6] = '{23'd33,  32'h0000_0025, 1'b1, 4'hA, 0, 2,  32'h0000_0001, 8'h8A};
    vecs[7] = '{23'd31,  32'h0000_0060, 1'b1, 4'hF, 0, 1,  32'h7FFF_FFFF, 8'h8F};

    rst = 1'b1;
    cmd_tvalid = 1'b0;
    cmd_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_tready", cmd_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
`ifdef DM_RESP_STS_EN
    chk("rst_sts_tvalid", sts_tvalid, 0);
    chk("rst_sts_tdata", sts_tdata, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("cmd_tready_after_reset", cmd_tready, 1);

    for (int v = 0; v < 8; v++) begin
      rmode = vecs[v].rmode;
      smode = 0;
      run_cmd(vecs[v].btt, vecs[v].addr, vecs[v].eof, vecs[v].tag, nb, lk, mb);
      chk($sformatf("vec%0d_beats", v), nb, vecs[v].exp_beats);
      if (vecs[v].exp_beats > 0) chk($sformatf("vec%0d_last_keep", v), lk, vecs[v].exp_keep);
`ifdef DM_RESP_STS_EN
      chk($sformatf("vec%0d_status", v), last_sts, vecs[v].exp_sts);
`endif
    end

    // Back-to-back commands with cmd_tvalid held high
    rmode = 0;
    smode = 0;
    model_push(23'd64, 32'h0000_0400, 1'b1, 4'h4, mb);
    model_push(23'd96, 32'h0000_0800, 1'b0, 4'h6, mb);
    cmd_tdata = {8'h00, 32'h0000_0400, 4'h0, 4'h4, 1'b1, 23'd64};
    cmd_tvalid = 1'b1;
    wait_hs("b2b_first_hs");
    cmd_tdata = {8'h00, 32'h0000_0800, 4'h0, 4'h6, 1'b0, 23'd96};
    wait_hs("b2b_second_hs");
    cmd_tvalid = 1'b0;
`ifdef DM_RESP_STS_EN
    chk("b2b_second_after_status", hs_cyc > sts_cyc, 1);
`else
    chk("b2b_second_after_drain", hs_cyc > beat_done_cyc, 1);
`endif
    wait_idle("b2b_done");

    // Reset while beat 2 of an 8-beat command is presented
    rmode = 0;
    model_push(23'd256, 32'h0000_1000, 1'b1, 4'hC, mb);
    base = n_acc;
    cmd_tdata = {8'h00, 32'h0000_1000, 4'h0, 4'hC, 1'b1, 23'd256};
    cmd_tvalid = 1'b1;
    wait_hs("rst_cmd_hs");
    cmd_tvalid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (n_acc - base >= 1) break;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_beat1_seen", n_acc - base, 1);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    sts_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_tkeep", m_tkeep, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_cmd_tready", cmd_tready, 0);
`ifdef DM_RESP_STS_EN
    chk("mid_rst_sts_tvalid", sts_tvalid, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cmd_tready_after", cmd_tready, 1);
    run_cmd(23'd32, 32'h0000_3000, 1'b1, 4'h1, nb, lk, mb);
    chk("post_rst_beats", nb, 1);

    // Randomized commands against the reference model
    for (int n = 0; n < 30; n++) begin
      rmode = 2;
      smode = 2;
      case ($urandom_range(0, 9))
        0:       rbtt = 23'd0;
        1:       rbtt = 23'($urandom_range(1, 32));
        default: rbtt = 23'($urandom_range(1, 640));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2: wa = 32'h0000_FFFF - 32'($urandom_range(0, 24));
        3:       wa = 32'h0001_0000 + 32'($urandom_range(0, 3));
        default: wa = 32'($urandom_range(0, 32'hFF00));
      endcase
      run_cmd(rbtt, (wa << 5) | 32'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), nb, lk, mb);
      chk("rand_beats", nb, mb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
